qspi_host_master: RTL and testbench
===================================

QSPI_HOST_MASTER -- requirements
Module: qspi_host_master

Interface
REQ-001 Parameter CMD_BITS, default 8: command length in bits; SHALL be a multiple of 4.
REQ-002 Parameter ADDR_BITS, default 32: address length in bits; SHALL be a multiple of 4.
REQ-003 Parameter WAIT_CYC, default 8: turnaround/dummy SCK cycles, read only; SHALL be >= 1.
REQ-004 Parameter DATA_BITS, default 16: data length in bits; SHALL be a multiple of 4.
REQ-005 Parameter SCK_HALF, default 2: clk_i cycles per SCK half-period; SHALL be >= 1.
REQ-006 clk_i  in  1  system clock, all logic on rising edge.
REQ-007 reset_i  in  1  asynchronous, active-low reset.
REQ-008 start_i  in  1  transaction request, accepted only when busy_o=0.
REQ-009 dir_i  in  1  0=read (slave to master), 1=write (master to slave).
REQ-010 cmd_i  in  CMD_BITS  command word.
REQ-011 addr_i  in  ADDR_BITS  address word.
REQ-012 wdata_i  in  DATA_BITS  write data.
REQ-013 busy_o  out  1  transaction in progress or CE recovery active.
REQ-014 done_o  out  1  one-cycle completion pulse.
REQ-015 rdata_o  out  DATA_BITS  read data, valid from done_o until the next accepted start.
REQ-016 sck_o  out  1  QSPI clock, idles low (mode 0).
REQ-017 sce_o  out  1  chip enable, active low.
REQ-018 sio_o  out  4  quad data out, bit 3 is the most significant nibble bit.
REQ-019 sio_oe  out  1  1=master drives sio_o.
REQ-020 sio_i  in  4  quad data in.

Function
REQ-021 States: IDLE, CMD, ADDR, WAIT, DATA, RECOV. Phases are quad (4 bits per SCK), MSB-first.
REQ-022 In IDLE, start_i=1 latches dir_i/cmd_i/addr_i/wdata_i; next cycle: state=CMD, sce_o=0, busy_o=1, sio_oe=1, first cmd nibble on sio_o, sck_o=0.
REQ-023 sck_o toggles every SCK_HALF clk cycles while sce_o=0; first rise occurs SCK_HALF cycles after sce_o falls.
REQ-024 Outgoing nibbles change only on the clk edge where sck_o falls (or at CE assertion for the first nibble) and are stable across the rising edge.
REQ-025 Phase lengths in SCK cycles: CMD=CMD_BITS/4, ADDR=ADDR_BITS/4, WAIT=WAIT_CYC (read only), DATA=DATA_BITS/4; write goes ADDR->DATA directly.
REQ-026 WAIT and read DATA: sio_oe=0 from the falling edge ending ADDR; sio_o=0 whenever sio_oe=0.
REQ-027 Read DATA: sio_i sampled on the clk edge where sck_o rises, shifted in MSB-first; rdata_o updates only when the transaction completes.
REQ-028 After the last DATA rising edge, the following falling edge ends the transaction: sce_o=1, sck_o=0, sio_oe=0, state=RECOV.
REQ-029 RECOV lasts 2*SCK_HALF clk cycles with busy_o=1; done_o pulses 1 cycle on RECOV entry; then IDLE, busy_o=0.
REQ-030 start_i while busy_o=1 is ignored and not queued.
REQ-031 Total SCK rises per transaction: read = CMD_BITS/4+ADDR_BITS/4+WAIT_CYC+DATA_BITS/4; write = the same without WAIT_CYC.
REQ-032 Phase counters are sized for the largest phase count and wrap to 0 at each phase change; there are no partial nibbles.
REQ-033 Latched inputs are held stable for the whole transaction; input changes mid-transaction have no effect.

Reset
REQ-034 reset_i=0 asynchronously forces IDLE, sce_o=1, sck_o=0, sio_oe=0, sio_o=0, busy_o=0, done_o=0, rdata_o=0, all counters=0.
REQ-035 Reset mid-transaction aborts it immediately, with no done_o pulse and no rdata_o update; after release the block accepts start_i on the first cycle.

Verification
REQ-036 Write, defaults, SCK_HALF=2: cmd=0x02, addr=0x00001234, wdata=0xBEEF -> 14 SCK rises; nibbles 0,2,0,0,0,0,1,2,3,4,B,E,E,F; sio_oe=1 throughout; done_o after CE rise.
REQ-037 Read, defaults: cmd=0x0B, addr=0x00000010; slave drives 0xA,0x5,0xC,0x3 on data rises -> 22 SCK rises; sio_oe=0 for 12 SCK cycles; rdata_o=0xA5C3.
REQ-038 CE timing: SCK_HALF=1 write -> sce_o low exactly 28 clk cycles, then high 2 cycles before busy_o=0.
REQ-039 Back-to-back: start_i held high continuously -> second transaction begins the cycle after busy_o falls; sce_o high >= 2*SCK_HALF cycles between.
REQ-040 Reset abort: assert reset_i=0 during ADDR phase -> same cycle sce_o=1, sio_oe=0; no done_o; rdata_o=0; a subsequent read completes correctly.

Source files
------------

// File: rtl/qspi_host_master.sv
// ---------------------------------------------------------------------------
// qspi_host_master
//
// Quad-SPI host that runs one command/address/(dummy)/data transaction per
// accepted start request. All phases move four bits per SCK cycle, most
// significant nibble first. SCK idles low (mode 0); outgoing nibbles change
// on SCK falling edges and incoming nibbles are sampled on SCK rising edges.
// After each transaction chip enable is held high for a recovery period
// before the next request can be accepted.
//
// Ports
//   clk_i      system clock, rising edge
//   reset_i    asynchronous active-low reset
//   start_i    transaction request, only taken while idle
//   dir_i      0 = read (slave to master), 1 = write (master to slave)
//   cmd_i      command word
//   addr_i     address word
//   wdata_i    write data
//   busy_o     transaction or CE recovery in progress
//   done_o     one-cycle pulse when a transaction completes
//   rdata_o    last read data, updated at transaction completion
//   sck_o      QSPI clock
//   sce_o      QSPI chip enable, active low
//   sio_o      quad data out, bit 3 is the most significant nibble bit
//   sio_oe     1 when the master drives sio_o
//   sio_i      quad data in
// ---------------------------------------------------------------------------
module qspi_host_master #(
    parameter int CMD_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int WAIT_CYC  = 8,
    parameter int DATA_BITS = 16,
    parameter int SCK_HALF  = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 dir_i,
    input  logic [CMD_BITS-1:0]  cmd_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DATA_BITS-1:0] rdata_o,
    output logic                 sck_o,
    output logic                 sce_o,
    output logic [3:0]           sio_o,
    output logic                 sio_oe,
    input  logic [3:0]           sio_i
);

    localparam int CMD_NIB    = CMD_BITS / 4;
    localparam int ADDR_NIB   = ADDR_BITS / 4;
    localparam int DATA_NIB   = DATA_BITS / 4;
    localparam int SHIFT_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

    // The nibble counter has to hold the longest phase of the transaction.
    localparam int MAX_AB  = (CMD_NIB > ADDR_NIB) ? CMD_NIB : ADDR_NIB;
    localparam int MAX_CD  = (WAIT_CYC > DATA_NIB) ? WAIT_CYC : DATA_NIB;
    localparam int MAX_NIB = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_NIB + 1);
    localparam int HALF_W  = $clog2(SCK_HALF + 1);
    localparam int REC_W   = $clog2(2 * SCK_HALF + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_RECOV = 3'd5;

    logic [2:0]            r_state;
    logic [HALF_W-1:0]     r_halfCnt;
    logic [CNT_W-1:0]      r_nibCnt;
    logic [REC_W-1:0]      r_recCnt;
    logic                  r_sck;
    logic                  r_sce;
    logic                  r_oe;
    logic                  r_done;
    logic                  r_dir;
    logic [SHIFT_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0]  r_rxShift;
    logic [DATA_BITS-1:0]  r_rdata;

    logic                  w_active;
    logic                  w_sckEdge;
    logic                  w_rise;
    logic                  w_fall;
    logic [CNT_W-1:0]      w_phaseLast;
    logic                  w_phaseEnd;

    // SCK toggles once its half-period counter expires; the current SCK
    // level tells whether that toggle is a rising or a falling edge.
    always_comb begin
        w_active  = (r_state == S_CMD) || (r_state == S_ADDR) ||
                    (r_state == S_WAIT) || (r_state == S_DATA);
        w_sckEdge = w_active && (r_halfCnt == HALF_W'(SCK_HALF - 1));
        w_rise    = w_sckEdge && !r_sck;
        w_fall    = w_sckEdge && r_sck;
    end

    // Index of the last SCK cycle of the current phase.
    always_comb begin
        w_phaseLast = '0;
        case (r_state)
            S_CMD:   w_phaseLast = CNT_W'(CMD_NIB - 1);
            S_ADDR:  w_phaseLast = CNT_W'(ADDR_NIB - 1);
            S_WAIT:  w_phaseLast = CNT_W'(WAIT_CYC - 1);
            S_DATA:  w_phaseLast = CNT_W'(DATA_NIB - 1);
            default: w_phaseLast = '0;
        endcase
        w_phaseEnd = (r_nibCnt == w_phaseLast);
    end

    // Transaction sequencer. Outgoing data sits in one shift register
    // (command, address, write data) and moves up a nibble on every SCK
    // falling edge. In read mode the shifted bits are never driven because
    // the output enable is already off, so shifting is left unconditional.
    // Phase transitions also happen on falling edges so each new phase
    // starts with SCK low.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state   <= S_IDLE;
            r_halfCnt <= '0;
            r_nibCnt  <= '0;
            r_recCnt  <= '0;
            r_sck     <= 1'b0;
            r_sce     <= 1'b1;
            r_oe      <= 1'b0;
            r_done    <= 1'b0;
            r_dir     <= 1'b0;
            r_shift   <= '0;
            r_rxShift <= '0;
            r_rdata   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_dir     <= dir_i;
                        r_shift   <= {cmd_i, addr_i, wdata_i};
                        r_rxShift <= '0;
                        r_sce     <= 1'b0;
                        r_oe      <= 1'b1;
                        r_sck     <= 1'b0;
                        r_halfCnt <= '0;
                        r_nibCnt  <= '0;
                        r_state   <= S_CMD;
                    end
                end

                S_RECOV: begin
                    if (r_recCnt == REC_W'(2 * SCK_HALF - 1)) begin
                        r_recCnt <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_recCnt <= r_recCnt + REC_W'(1);
                    end
                end

                default: begin
                    if (w_sckEdge) begin
                        r_halfCnt <= '0;
                        r_sck     <= ~r_sck;
                    end else begin
                        r_halfCnt <= r_halfCnt + HALF_W'(1);
                    end

                    if (w_rise && (r_state == S_DATA) && !r_dir) begin
                        r_rxShift <= DATA_BITS'({r_rxShift, sio_i});
                    end

                    if (w_fall) begin
                        r_shift <= {r_shift[SHIFT_BITS-5:0], 4'b0000};
                        if (w_phaseEnd) begin
                            r_nibCnt <= '0;
                            case (r_state)
                                S_CMD:  r_state <= S_ADDR;
                                S_ADDR: begin
                                    if (r_dir) begin
                                        r_state <= S_DATA;
                                    end else begin
                                        r_state <= S_WAIT;
                                        r_oe    <= 1'b0;
                                    end
                                end
                                S_WAIT: r_state <= S_DATA;
                                default: begin
                                    r_state  <= S_RECOV;
                                    r_sce    <= 1'b1;
                                    r_oe     <= 1'b0;
                                    r_done   <= 1'b1;
                                    r_recCnt <= '0;
                                    if (!r_dir) begin
                                        r_rdata <= r_rxShift;
                                    end
                                end
                            endcase
                        end else begin
                            r_nibCnt <= r_nibCnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy_o  = (r_state != S_IDLE);
        done_o  = r_done;
        rdata_o = r_rdata;
        sck_o   = r_sck;
        sce_o   = r_sce;
        sio_oe  = r_oe;
        sio_o   = r_oe ? r_shift[SHIFT_BITS-1 -: 4] : 4'b0000;
    end

endmodule

// File: tb/tb_qspi_host_master.sv
// ---------------------------------------------------------------------------
// tb_qspi_host_master
//
// Self-checking bench for qspi_host_master. The main instance uses the
// default parameters (SCK_HALF = 2); a second instance with SCK_HALF = 1 is
// used for chip-enable timing. Transactions are observed at the pin level
// and compared with values derived from the protocol rules: nibble stream,
// SCK rise counts, output-enable windows, done pulse and read data.
// ---------------------------------------------------------------------------
module tb_qspi_host_master;

    localparam int CMD_N  = 2;
    localparam int ADDR_N = 8;
    localparam int WAIT_N = 8;
    localparam int DATA_N = 4;

    logic        clk;
    logic        resetN;
    logic        start;
    logic        startF;
    logic        dir;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [3:0]  sioIn;

    logic        busy, done, sck, sce, sioOe;
    logic [15:0] rdata;
    logic [3:0]  sioOut;

    logic        busyF, doneF, sckF, sceF, sioOeF;
    logic [15:0] rdataF;
    logic [3:0]  sioOutF;

    int checkCount = 0;
    int passCount  = 0;

    qspi_host_master dut (
        .clk_i(clk), .reset_i(resetN), .start_i(start), .dir_i(dir),
        .cmd_i(cmd), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy), .done_o(done), .rdata_o(rdata),
        .sck_o(sck), .sce_o(sce), .sio_o(sioOut), .sio_oe(sioOe), .sio_i(sioIn)
    );

    qspi_host_master #(.SCK_HALF(1)) dutFast (
        .clk_i(clk), .reset_i(resetN), .start_i(startF), .dir_i(dir),
        .cmd_i(cmd), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busyF), .done_o(doneF), .rdata_o(rdataF),
        .sck_o(sckF), .sce_o(sceF), .sio_o(sioOutF), .sio_oe(sioOeF), .sio_i(sioIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one transaction on the main instance and records what the pins
    // did. The slave model presents read nibble k just after the SCK rise
    // that precedes the k-th data rise, and random junk at all other times.
    task automatic observeTxn(
        input  logic        d,
        input  logic [7:0]  c,
        input  logic [31:0] a,
        input  logic [15:0] w,
        input  logic [15:0] sd,
        input  bit          pulseMid,
        output int          rises,
        output logic [63:0] obsBits,
        output int          oeLow,
        output int          doneCnt,
        output int          doneBad,
        output int          glitches,
        output int          sceLow,
        output bit          timedOut
    );
        int pre;
        int idx;
        logic prevSck, prevSce;
        logic [3:0] prevSio;
        pre = CMD_N + ADDR_N + WAIT_N;
        rises = 0; obsBits = '0; oeLow = 0; doneCnt = 0; doneBad = 0;
        glitches = 0; sceLow = 0; timedOut = 1'b1;
        @(negedge clk);
        prevSck = sck; prevSce = sce; prevSio = sioOut;
        dir = d; cmd = c; addr = a; wdata = w; start = 1'b1;
        sioIn = 4'($urandom);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                start = 1'b0;
                dir   = 1'($urandom);
                cmd   = 8'($urandom);
                addr  = $urandom;
                wdata = 16'($urandom);
            end
            if (!sce) sceLow++;
            if (sck && !prevSck) begin
                rises++;
                if (sioOe) obsBits = {obsBits[59:0], sioOut};
                else oeLow++;
                idx = rises - pre;
                if (!d && idx >= 0 && idx < DATA_N) sioIn = sd[15 - 4*idx -: 4];
                else sioIn = 4'($urandom);
            end
            if (sioOut !== prevSio && !(prevSck && !sck) && !(prevSce && !sce)) glitches++;
            if (done) begin
                doneCnt++;
                if (!sce) doneBad++;
            end
            if (pulseMid) start = (rises == 5 && sck);
            prevSck = sck; prevSce = sce; prevSio = sioOut;
            if (!busy) begin
                timedOut = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0; start = 1'b0; startF = 1'b0;
        dir = 1'b0; cmd = '0; addr = '0; wdata = '0; sioIn = '0;
        repeat (3) @(negedge clk);
        checkCount++; if (sce !== 1'b1) $display("[TB] FAIL reset_sce: got %b expected 1", sce); else passCount++;
        checkCount++; if (sck !== 1'b0) $display("[TB] FAIL reset_sck: got %b expected 0", sck); else passCount++;
        checkCount++; if (sioOe !== 1'b0) $display("[TB] FAIL reset_oe: got %b expected 0", sioOe); else passCount++;
        checkCount++; if (sioOut !== 4'h0) $display("[TB] FAIL reset_sio: got %h expected 0", sioOut); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passCount++;
        checkCount++; if (rdata !== 16'h0) $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); else passCount++;
        checkCount++; if ({sceF, sckF, sioOeF, sioOutF, busyF, doneF, rdataF} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0})
            $display("[TB] FAIL reset_fast: got %b%b%b %h %b%b %h expected 100 0 00 0000", sceF, sckF, sioOeF, sioOutF, busyF, doneF, rdataF);
        else passCount++;
        @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        checkCount++; if (busy !== 1'b0 || sce !== 1'b1) $display("[TB] FAIL idle_after_reset: got busy=%b sce=%b expected 0/1", busy, sce); else passCount++;
    endtask

    task automatic test_write_fixed();
        int rises, oeLow, doneCnt, doneBad, glitches, sceLow;
        logic [63:0] bits;
        bit tmo;
        observeTxn(1'b1, 8'h02, 32'h00001234, 16'hBEEF, 16'h0, 1'b0,
                   rises, bits, oeLow, doneCnt, doneBad, glitches, sceLow, tmo);
        checkCount++; if (tmo) $display("[TB] FAIL wr_timeout: got busy stuck expected idle"); else passCount++;
        checkCount++; if (rises !== 14) $display("[TB] FAIL wr_rises: got %0d expected 14", rises); else passCount++;
        checkCount++; if (bits !== 64'h0002_0000_1234_BEEF) $display("[TB] FAIL wr_nibbles: got %h expected 000200001234beef", bits); else passCount++;
        checkCount++; if (oeLow !== 0) $display("[TB] FAIL wr_oe: got %0d oe-low rises expected 0", oeLow); else passCount++;
        checkCount++; if (doneCnt !== 1 || doneBad !== 0) $display("[TB] FAIL wr_done: got %0d pulses (%0d with CE low) expected 1 (0)", doneCnt, doneBad); else passCount++;
        checkCount++; if (glitches !== 0) $display("[TB] FAIL wr_stable: got %0d illegal sio changes expected 0", glitches); else passCount++;
        checkCount++; if (sceLow !== 56) $display("[TB] FAIL wr_ce_low: got %0d expected 56", sceLow); else passCount++;
    endtask

    task automatic test_read_fixed();
        int rises, oeLow, doneCnt, doneBad, glitches, sceLow;
        logic [63:0] bits;
        bit tmo;
        observeTxn(1'b0, 8'h0B, 32'h00000010, 16'h0, 16'hA5C3, 1'b0,
                   rises, bits, oeLow, doneCnt, doneBad, glitches, sceLow, tmo);
        checkCount++; if (tmo) $display("[TB] FAIL rd_timeout: got busy stuck expected idle"); else passCount++;
        checkCount++; if (rises !== 22) $display("[TB] FAIL rd_rises: got %0d expected 22", rises); else passCount++;
        checkCount++; if (bits !== 64'h0000_000B_0000_0010) $display("[TB] FAIL rd_nibbles: got %h expected 0000000b00000010", bits); else passCount++;
        checkCount++; if (oeLow !== 12) $display("[TB] FAIL rd_oe: got %0d oe-low rises expected 12", oeLow); else passCount++;
        checkCount++; if (rdata !== 16'hA5C3) $display("[TB] FAIL rd_data: got %h expected a5c3", rdata); else passCount++;
        checkCount++; if (doneCnt !== 1 || doneBad !== 0) $display("[TB] FAIL rd_done: got %0d pulses (%0d with CE low) expected 1 (0)", doneCnt, doneBad); else passCount++;
        checkCount++; if (glitches !== 0) $display("[TB] FAIL rd_stable: got %0d illegal sio changes expected 0", glitches); else passCount++;
    endtask

    task automatic test_random();
        int rises, oeLow, doneCnt, doneBad, glitches, sceLow;
        int expRises;
        logic [63:0] bits, expBits;
        logic [15:0] prevRdata;
        bit tmo;
        logic d;
        logic [7:0] c;
        logic [31:0] a;
        logic [15:0] w, sd;
        for (int n = 0; n < 8; n++) begin
            d = 1'($urandom); c = 8'($urandom); a = $urandom;
            w = 16'($urandom); sd = 16'($urandom);
            prevRdata = rdata;
            observeTxn(d, c, a, w, sd, 1'b0, rises, bits, oeLow, doneCnt, doneBad, glitches, sceLow, tmo);
            expRises = d ? (CMD_N + ADDR_N + DATA_N) : (CMD_N + ADDR_N + WAIT_N + DATA_N);
            expBits  = d ? {8'h00, c, a, w} : {24'h0, c, a};
            checkCount++; if (tmo || rises !== expRises) $display("[TB] FAIL rnd_rises: got %0d expected %0d (dir %b)", rises, expRises, d); else passCount++;
            checkCount++; if (bits !== expBits) $display("[TB] FAIL rnd_nibbles: got %h expected %h (dir %b)", bits, expBits, d); else passCount++;
            checkCount++; if (oeLow !== (d ? 0 : WAIT_N + DATA_N)) $display("[TB] FAIL rnd_oe: got %0d expected %0d", oeLow, d ? 0 : WAIT_N + DATA_N); else passCount++;
            checkCount++; if (rdata !== (d ? prevRdata : sd)) $display("[TB] FAIL rnd_rdata: got %h expected %h (dir %b)", rdata, d ? prevRdata : sd, d); else passCount++;
            checkCount++; if (doneCnt !== 1 || glitches !== 0 || sceLow !== 4*expRises)
                $display("[TB] FAIL rnd_timing: got done=%0d glitches=%0d ceLow=%0d expected 1 0 %0d", doneCnt, glitches, sceLow, 4*expRises);
            else passCount++;
        end
    endtask

    task automatic test_busy_ignore();
        int rises, oeLow, doneCnt, doneBad, glitches, sceLow;
        logic [63:0] bits;
        bit tmo;
        int busySeen;
        observeTxn(1'b1, 8'h5A, 32'hCAFE0001, 16'h1357, 16'h0, 1'b1,
                   rises, bits, oeLow, doneCnt, doneBad, glitches, sceLow, tmo);
        checkCount++; if (tmo || bits !== 64'h005A_CAFE_0001_1357) $display("[TB] FAIL busy_txn: got %h expected 005acafe00011357", bits); else passCount++;
        busySeen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || !sce) busySeen++;
        end
        checkCount++; if (busySeen !== 0) $display("[TB] FAIL busy_not_queued: got %0d busy cycles expected 0", busySeen); else passCount++;
    endtask

    task automatic test_back_to_back();
        int gap, busyLow, phase;
        bit tmo;
        @(negedge clk);
        dir = 1'b1; cmd = 8'h38; addr = 32'h0000_0100; wdata = 16'h55AA; start = 1'b1;
        gap = 0; busyLow = 0; phase = 0; tmo = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (phase == 0) begin
                if (done) begin
                    phase = 1;
                    gap = sce ? 1 : 0;
                end
            end else begin
                if (!busy) busyLow++;
                if (sce) gap++;
                else begin
                    tmo = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        checkCount++; if (tmo) $display("[TB] FAIL b2b_second_start: got no second transaction expected one"); else passCount++;
        checkCount++; if (busyLow !== 1) $display("[TB] FAIL b2b_idle_cycles: got %0d expected 1", busyLow); else passCount++;
        checkCount++; if (gap < 4) $display("[TB] FAIL b2b_ce_gap: got %0d expected >= 4", gap); else passCount++;
        tmo = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (!busy) begin
                tmo = 1'b0;
                break;
            end
        end
        checkCount++; if (tmo) $display("[TB] FAIL b2b_finish: got busy stuck expected idle"); else passCount++;
    endtask

    task automatic test_ce_timing();
        int lowCnt, recovCnt, phase;
        bit tmo;
        @(negedge clk);
        dir = 1'b1; cmd = 8'h02; addr = 32'h0000_1234; wdata = 16'hBEEF; startF = 1'b1;
        lowCnt = 0; recovCnt = 0; phase = 0; tmo = 1'b1;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            startF = 1'b0;
            if (!sceF) lowCnt++;
            else if (busyF) recovCnt++;
            if (!busyF) begin
                tmo = 1'b0;
                break;
            end
        end
        checkCount++; if (tmo || lowCnt !== 28) $display("[TB] FAIL ce_low_cycles: got %0d expected 28", lowCnt); else passCount++;
        checkCount++; if (recovCnt !== 2) $display("[TB] FAIL ce_recovery: got %0d expected 2", recovCnt); else passCount++;
    endtask

    task automatic test_reset_abort();
        int rises, oeLow, doneCnt, doneBad, glitches, sceLow, doneSeen;
        logic [63:0] bits;
        logic prevSck;
        logic [15:0] sd;
        bit tmo;
        @(negedge clk);
        dir = 1'b0; cmd = 8'h0B; addr = 32'h0000_0020; start = 1'b1;
        prevSck = sck; rises = 0; tmo = 1'b1;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (sck && !prevSck) rises++;
            prevSck = sck;
            if (rises == 3) begin
                tmo = 1'b0;
                break;
            end
        end
        resetN = 1'b0;
        #1;
        checkCount++; if (tmo) $display("[TB] FAIL abort_reach_addr: got no ADDR phase expected one"); else passCount++;
        checkCount++; if (sce !== 1'b1 || sioOe !== 1'b0 || sck !== 1'b0 || sioOut !== 4'h0)
            $display("[TB] FAIL abort_pins: got sce=%b oe=%b sck=%b sio=%h expected 1 0 0 0", sce, sioOe, sck, sioOut);
        else passCount++;
        checkCount++; if (busy !== 1'b0 || rdata !== 16'h0) $display("[TB] FAIL abort_state: got busy=%b rdata=%h expected 0 0000", busy, rdata); else passCount++;
        @(negedge clk);
        resetN = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        checkCount++; if (doneSeen !== 0) $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", doneSeen); else passCount++;
        sd = 16'($urandom);
        observeTxn(1'b0, 8'h6B, 32'h00ABCDEF, 16'h0, sd, 1'b0,
                   rises, bits, oeLow, doneCnt, doneBad, glitches, sceLow, tmo);
        checkCount++; if (tmo || rises !== 22 || rdata !== sd)
            $display("[TB] FAIL abort_then_read: got rises=%0d rdata=%h expected 22 %h", rises, rdata, sd);
        else passCount++;
    endtask

    // Test sequence, followed by the single summary line.
    initial begin
        test_reset();
        test_write_fixed();
        test_read_fixed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_ce_timing();
        test_reset_abort();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
